// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath: UART receive stage; start bit, 8 data bits LSB first, optional parity, one stop bit.
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   rx_in          in   asynchronous serial line, idles high
//   parity_enable  in   frame carries a parity bit (latched at start detection)
//   rx_data        out  last received byte
//   rx_valid       out  one-cycle strobe: rx_data and error flags updated
//   parity_err     out  parity mismatch on the last frame
//   frame_err      out  stop bit sampled low on the last frame
//   busy           out  receiver is inside a frame
module uart_rx_datapath #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_TYPE  = 0,
    parameter int CNT_WIDTH    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       parity_enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic sync1, rx_s, rx_s_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic par_en_q, perr_q;
    logic half, full, fall;
    assign half = cnt == CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    assign full = cnt == CNT_WIDTH'(CLKS_PER_BIT - 1);
    assign fall = rx_s_d && !rx_s;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = fall ? START : IDLE;
            // mid start bit: a high line here means the edge was a glitch
            START:   state_n = half ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_n = (full && bit_idx == 3'd7) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_n = full ? STOP : PARITY;
            // leaving at mid-stop lets a back-to-back start edge be caught
            STOP:    state_n = full ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            rx_s_d     <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            perr_q     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1    <= rx_in;
            rx_s     <= sync1;
            rx_s_d   <= rx_s;
            rx_valid <= 1'b0;
            cnt      <= (state == IDLE || (state == START && half) || full) ? '0 : cnt + CNT_WIDTH'(1);
            if (state == IDLE && fall) par_en_q <= parity_enable;
            if (state == DATA && full) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == PARITY && full) perr_q <= ^{shreg, rx_s} ^ (PARITY_TYPE != 0);
            if (state == STOP && full) begin
                rx_data    <= shreg;
                parity_err <= par_en_q && perr_q;
                frame_err  <= !rx_s;
                rx_valid   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_datapath.sv
// tb_uart_rx_datapath: self-checking bench for uart_rx_datapath (N=16, even parity).
module tb_uart_rx_datapath;
    localparam int N = 16;
    localparam int PT = 0;
    logic clk = 1'b0, reset = 1'b1, rx_in = 1'b1, parity_enable = 1'b0;
    logic [7:0] rx_data;
    logic rx_valid, parity_err, frame_err, busy;
    int checks = 0, failures = 0, cyc = 0, busy_cnt = 0, fall = 0;
    logic [7:0] last_d = 8'h00;
    logic last_pe = 1'b0, last_fe = 1'b0;
    typedef struct { logic [7:0] data; logic perr; logic ferr; int t; } evt_t;
    typedef struct { logic [7:0] data; logic pen; logic pbit; logic stop; logic [7:0] exp_d; logic exp_pe; logic exp_fe; } vec_t;
    evt_t evq[$];
    vec_t vecs[9];

    uart_rx_datapath #(.CLKS_PER_BIT(N), .PARITY_TYPE(PT), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .parity_enable(parity_enable),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rx_valid) evq.push_back('{rx_data, parity_err, frame_err, cyc});
        if (busy) busy_cnt++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (N) step();
    endtask

    // parity_enable is flipped after the start bit to show it is latched at detection
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
        parity_enable = pen;
        fall = cyc;
        send_bit(1'b0);
        parity_enable = ~pen;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stop);
        rx_in = 1'b1;
    endtask

    function automatic logic model_perr(input logic [7:0] d, input logic pen, input logic pbit);
        return pen && ((($countones(d) + int'(pbit)) % 2) != PT);
    endfunction

    task automatic expect_frame(input string nm, input logic [7:0] d, input logic pe, input logic fe);
        evt_t e;
        chk({nm, "_count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({nm, "_data"}, e.data, d);
            chk({nm, "_perr"}, e.perr, pe);
            chk({nm, "_ferr"}, e.ferr, fe);
        end
        evq.delete();
        last_d = d;
        last_pe = pe;
        last_fe = fe;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[7] = '{8'h81, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
        vecs[8] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

        repeat (4) step();
        chk("reset_data", rx_data, 0);
        chk("reset_valid", rx_valid, 0);
        chk("reset_perr", parity_err, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        repeat (N) step();

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
            if (i == 0 && evq.size() > 0) chk_rng("latency", evq[0].t - fall, 154, 156);
            repeat (2 * N) step();
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
        end

        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic pen, pbit, stop;
            d = 8'($urandom);
            pen = 1'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, pen, pbit, stop);
            repeat (2 * N) step();
            expect_frame($sformatf("rand%0d", i), d, model_perr(d, pen, pbit), !stop);
        end

        busy_cnt = 0;
        rx_in = 1'b0;
        repeat (4) step();
        rx_in = 1'b1;
        repeat (2 * N) step();
        chk("glitch_no_valid", evq.size(), 0);
        chk_rng("glitch_busy_cycles", busy_cnt, 1, N / 2);
        chk("glitch_data_hold", rx_data, last_d);
        chk("glitch_perr_hold", parity_err, last_pe);
        chk("glitch_ferr_hold", frame_err, last_fe);
        evq.delete();

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b0;
        busy_cnt = 0;
        repeat (40 * N) step();
        chk("break_busy_cycles", busy_cnt, 0);
        expect_frame("break", 8'h3C, 1'b0, 1'b1);
        rx_in = 1'b1;
        repeat (2 * N) step();
        chk("break_release_quiet", evq.size(), 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        repeat (2 * N) step();
        expect_frame("after_break", 8'h81, 1'b0, 1'b0);

        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        repeat (2 * N) step();
        chk("b2b_count", evq.size(), 3);
        if (evq.size() == 3) begin
            chk("b2b_d0", evq[0].data, 8'h00);
            chk("b2b_d1", evq[1].data, 8'hFF);
            chk("b2b_d2", evq[2].data, 8'h55);
            chk("b2b_gap01", evq[1].t - evq[0].t, 10 * N);
            chk("b2b_gap12", evq[2].t - evq[1].t, 10 * N);
        end
        evq.delete();

        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        repeat (2 * N) step();
        expect_frame("pre_reset", 8'hC3, 1'b0, 1'b1);
        parity_enable = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rx_in = 1'b0;
        repeat (N / 2) step();
        chk("midframe_busy", busy, 1);
        reset = 1'b1;
        rx_in = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_data", rx_data, 0);
        chk("rst_mid_valid", rx_valid, 0);
        chk("rst_mid_perr", parity_err, 0);
        chk("rst_mid_ferr", frame_err, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (12 * N) step();
        chk("rst_mid_no_valid", evq.size(), 0);
        evq.delete();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (2 * N) step();
        expect_frame("after_reset", 8'h5A, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
